pak_crc_checker: RTL and testbench
==================================

# pak_crc_checker

Receive-side counterpart of the serial CRC-8 generator used for controller-pak data. It consumes a serial frame bit by bit, MSB first: a fixed-length data block followed by the sender's 8-bit CRC. While the block arrives it recomputes the CRC over the block plus eight augmenting zero bits, then reports the CRC it computed, the CRC it received, and a match flag. It sits between the joybus bit-slicer (which supplies `bit_valid` strobes) and the pak command handler (which consumes `done`/`crc_ok`).

## Interface
Parameters:
- `SEED`, 8'h00: initial CRC window value, loaded at reset and on every `start`.
- `DATA_BYTES`, 32: payload length in bytes. Legal range is 1..255.
- `POLY`, 8'h85: feedback polynomial x^8+x^7+x^2+1, low 8 bits.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a new frame.
- `bit_valid` in 1: the value on `bit_in` is accepted this cycle.
- `bit_in` in 1: serial data, MSB of each byte first.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse when the frame is complete.
- `crc_ok` out 1: `calc_crc == rx_crc`. Valid with `done` and held until the next `start`.
- `calc_crc` out 8: the CRC window (the computed remainder).
- `rx_crc` out 8: the CRC byte received from the sender.

## Operation
- CRC step for input bit d: `w <= {w[6:0], d} ^ (w[7] ? POLY : 8'h00)`. This is identical to the generator's update rule.
- State IDLE:
  - `start` loads `SEED` into the window, clears `rx_crc` and the bit counter, clears `crc_ok`, and moves to DATA.
  - `bit_valid` is ignored in IDLE.
- State DATA:
  - Each `bit_valid` applies a CRC step with d=`bit_in` and increments the 11-bit bit counter.
  - After DATA_BYTES*8 accepted bits, clear the counter and move to CRC.
- State CRC:
  - Each `bit_valid` shifts `bit_in` into `rx_crc` from the LSB end (so the first received bit ends at bit 7).
  - The same `bit_valid` applies a CRC step with d=0; this supplies the augmenting zero byte.
  - After 8 accepted bits, move to DONE.
- State DONE, one cycle:
  - Assert `done` and register `crc_ok` from the comparison.
  - Return to IDLE.
- `start` in any non-IDLE state restarts the frame exactly as from IDLE. A `bit_valid` in that same cycle is dropped.
- `start` in the DONE cycle also restarts. `done` still pulses in that cycle.
- Gaps of any length between `bit_valid` strobes are legal. No timeout.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `crc_ok`=0
  - `calc_crc`=`SEED`, `rx_crc`=8'h00
  - bit counter 0
- `busy` rises the cycle after `start` is sampled.
- `calc_crc` reflects every accepted bit one cycle after the `bit_valid` that carried it.
- `done` is high exactly one cycle, in the cycle after the 8th CRC bit is accepted. `busy` falls in that same cycle.
- `crc_ok` is valid from the `done` cycle onward. `calc_crc` and `rx_crc` hold their values until the next `start`.
- Throughput: one bit per cycle when `bit_valid` is held high.
  - Minimum frame is DATA_BYTES*8+8 cycles, plus one cycle for `start` and one for DONE.
- `reset` mid-frame returns the block to its reset values on the next edge, with no `done` pulse. `reset` has priority over `start`.

## Structure
- Package `crc8_pkg` holds:
  - `CRC8_POLY` = 8'h85 and `CRC8_SEED` = 8'h00
  - the state enum: IDLE, DATA, CRC, DONE
  - the function `crc8_step(w, d, poly)`
- The generator will also adopt `crc8_step`, so sender and checker share one update rule.
- One optional sub-module, `crc8_lfsr` (window register with load/step/zero-step controls). Acceptable either inline or instantiated.

## Test plan
- Single-bit payload: `DATA_BYTES`=32, 31 bytes of 0x00 then 0x01, CRC byte 0x85 -> `done` pulses once, `calc_crc`=0x85, `rx_crc`=0x85, `crc_ok`=1.
- All-zero payload: 32 bytes of 0x00, CRC 0x00 -> `crc_ok`=1, `calc_crc`=0x00.
- Mismatch: the single-bit payload with CRC 0x84 -> `crc_ok`=0, `calc_crc`=0x85, `rx_crc`=0x84.
- Gapped strobes: the single-bit payload with random 0..5-cycle gaps between `bit_valid` strobes -> same result as the first case; `busy` stays high throughout.
- Restart and reset: `start` after 100 bits, then a full all-zero frame -> `crc_ok`=1, exactly one `done`. Separately, `reset` after 200 bits -> all outputs at reset values, no `done`.
- Parameter sweep: `DATA_BYTES`=1, payload 0x01, CRC 0x85 -> `crc_ok`=1, `done` exactly 1 cycle after the 16th accepted bit.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the controller-pak serial CRC generator and checker.
// Holds the default polynomial and seed, the checker state enum and the
// single-bit window update rule that both ends of the link use.
package crc8_pkg;

  localparam logic [7:0]  CRC8_POLY = 8'h85;  // x^8+x^7+x^2+1, x^8 term implied
  localparam logic [7:0]  CRC8_SEED = 8'h00;
  localparam int unsigned CNT_W     = 11;     // bit counter, covers 255*8 data bits

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } crc_state_e;

  // One serial step: shift d in at the LSB, fold the bit falling off the top.
  function automatic logic [7:0] crc8_step(input logic [7:0] w, input logic d,
                                           input logic [7:0] poly);
    return {w[6:0], d} ^ (w[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// CRC-8 window register.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (loads SEED)
//   load_i        : reload SEED (new frame)
//   step_i        : apply one CRC step with data bit d_i
//   zero_i        : apply one CRC step with a zero data bit (augmentation)
//   d_i           : serial data bit
//   win_o         : current window (registered)
// Priority: reset > load_i > step_i > zero_i.
module crc8_lfsr
  import crc8_pkg::*;
#(
  parameter logic [7:0] SEED = CRC8_SEED,
  parameter logic [7:0] POLY = CRC8_POLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       step_i,
  input  logic       zero_i,
  input  logic       d_i,
  output logic [7:0] win_o
);

  logic [7:0] win_q;

  always_ff @(posedge clk) begin
    if (reset || load_i) begin
      win_q <= SEED;
    end else if (step_i) begin
      win_q <= crc8_step(win_q, d_i, POLY);
    end else if (zero_i) begin
      win_q <= crc8_step(win_q, 1'b0, POLY);
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/pak_crc_checker.sv
// Receive-side CRC-8 checker for controller-pak frames.
// Consumes DATA_BYTES of serial payload (MSB first) followed by the sender's
// CRC byte, recomputes the CRC over payload plus eight augmenting zeros and
// reports computed CRC, received CRC and a match flag.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle pulse, (re)starts a frame from any state
//   bit_valid    : bit_in is accepted this cycle
//   bit_in       : serial data bit
//   busy         : frame in progress (cycle after start until done)
//   done         : one-cycle completion pulse
//   crc_ok       : calc_crc == rx_crc, valid from done until next start
//   calc_crc     : computed CRC window
//   rx_crc       : received CRC byte
module pak_crc_checker
  import crc8_pkg::*;
#(
  parameter logic [7:0]  SEED       = CRC8_SEED,
  parameter int unsigned DATA_BYTES = 32,
  parameter logic [7:0]  POLY       = CRC8_POLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       busy,
  output logic       done,
  output logic       crc_ok,
  output logic [7:0] calc_crc,
  output logic [7:0] rx_crc
);

  localparam logic [CNT_W-1:0] LAST_DATA = 11'(DATA_BYTES * 8 - 1);
  localparam logic [CNT_W-1:0] LAST_CRC  = 11'd7;

  crc_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       rx_q;
  logic             busy_q;
  logic             done_q;
  logic             ok_q;

  // A bit_valid coinciding with start is dropped.
  logic       accept_c;
  logic       data_step_c;
  logic       zero_step_c;
  logic [7:0] rx_next_c;
  logic [7:0] calc_next_c;

  assign accept_c    = bit_valid & ~start;
  assign data_step_c = (state_q == DATA) & accept_c;
  assign zero_step_c = (state_q == CRC) & accept_c;
  assign rx_next_c   = {rx_q[6:0], bit_in};
  assign calc_next_c = crc8_step(calc_crc, 1'b0, POLY);

  crc8_lfsr #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load_i (start),
    .step_i (data_step_c),
    .zero_i (zero_step_c),
    .d_i    (bit_in),
    .win_o  (calc_crc)
  );

  // Frame sequencing. crc_ok is compared using the post-step window and
  // received byte so it is already valid in the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= DATA;
        cnt_q   <= '0;
        rx_q    <= 8'h00;
        ok_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
          end
          DATA: begin
            if (bit_valid) begin
              if (cnt_q == LAST_DATA) begin
                cnt_q   <= '0;
                state_q <= CRC;
              end else begin
                cnt_q <= cnt_q + 11'd1;
              end
            end
          end
          CRC: begin
            if (bit_valid) begin
              rx_q <= rx_next_c;
              if (cnt_q == LAST_CRC) begin
                cnt_q   <= '0;
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                ok_q    <= (calc_next_c == rx_next_c);
              end else begin
                cnt_q <= cnt_q + 11'd1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign crc_ok = ok_q;
  assign rx_crc = rx_q;

endmodule

// File: tb/tb_pak_crc_checker.sv
// Bench for pak_crc_checker: a polynomial-division reference model tracks the
// accepted bit stream and every output is compared on each falling edge;
// directed frames add literal expectations, then randomized frames follow.
module tb_pak_crc_checker;

  localparam int NB    = 32;
  localparam int NBITS = NB * 8;
  localparam int BIG   = 100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, bit_valid, bit_in;
  logic       busy, done, crc_ok;
  logic [7:0] calc_crc, rx_crc;

  logic       start2, bv2, bi2;
  logic       busy2, done2, ok2;
  logic [7:0] calc2, rx2;

  pak_crc_checker #(.SEED(8'h00), .DATA_BYTES(NB), .POLY(8'h85)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy), .done(done), .crc_ok(crc_ok), .calc_crc(calc_crc), .rx_crc(rx_crc)
  );

  pak_crc_checker #(.SEED(8'h00), .DATA_BYTES(1), .POLY(8'h85)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bit_valid(bv2), .bit_in(bi2),
    .busy(busy2), .done(done2), .crc_ok(ok2), .calc_crc(calc2), .rx_crc(rx2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Remainder of the bit string (MSB first) modulo x^8+POLY, by long division.
  function automatic logic [7:0] mod_p(input bit q[$]);
    logic [7:0] p;
    logic [7:0] r;
    bit a[];
    int n;
    p = 8'h85;
    n = q.size();
    a = new[n + 8];
    for (int i = 0; i < 8; i++) a[i] = 1'b0;
    for (int i = 0; i < n; i++) a[i + 8] = q[i];
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        a[i] = 1'b0;
        for (int j = 0; j < 8; j++) a[i + 1 + j] = a[i + 1 + j] ^ p[7 - j];
      end
    end
    for (int j = 0; j < 8; j++) r[7 - j] = a[n + j];
    return r;
  endfunction

  // Reference model: what has been accepted since the last start.
  bit         m_active = 1'b0;
  bit         fed[$];
  int         m_nacc = 0;
  logic [7:0] m_rx = 8'h00;
  bit         m_done = 1'b0;
  bit         m_ok = 1'b0;
  bit         checking = 1'b0;
  int         done_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      fed.delete();
      m_nacc = 0;
      m_rx   = 8'h00;
      m_done = 1'b0;
      m_ok   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_active = 1'b1;
        fed.delete();
        m_nacc = 0;
        m_rx   = 8'h00;
        m_ok   = 1'b0;
      end else if (m_active && bit_valid) begin
        if (m_nacc < NBITS) begin
          fed.push_back(bit_in);
        end else begin
          fed.push_back(1'b0);
          m_rx = {m_rx[6:0], bit_in};
        end
        m_nacc++;
        if (m_nacc == NBITS + 8) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_ok     = (mod_p(fed) == m_rx);
        end
      end
    end
  end

  // Compare process.
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", 8'(busy), 8'(m_active));
      chk("done", 8'(done), 8'(m_done));
      chk("crc_ok", 8'(crc_ok), 8'(m_ok));
      chk("calc_crc", calc_crc, mod_p(fed));
      chk("rx_crc", rx_crc, m_rx);
      if (done === 1'b1) done_cnt++;
    end
  end

  logic [7:0] pay [NB];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start     = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'($urandom_range(0, 1));
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom_range(0, 1));
      tick();
    end
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // Start, then send up to 'limit' bits of payload followed by the CRC byte.
  task automatic frame(input logic [7:0] crc, input int maxgap, input int limit);
    do_start();
    for (int i = 0; i < NBITS + 8 && i < limit; i++) begin
      logic       b;
      logic [7:0] by;
      if (i < NBITS) begin
        by = pay[i / 8];
        b  = by[7 - (i % 8)];
      end else begin
        b = crc[7 - (i - NBITS)];
      end
      send_bit(b, maxgap);
    end
  endtask

  // Idle cycles with stray strobes that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic expect_done(input string name, input logic [7:0] c, input logic [7:0] r,
                             input logic ok);
    chk({name, "_done"}, 8'(done), 8'h01);
    chk({name, "_busy"}, 8'(busy), 8'h00);
    chk({name, "_calc"}, calc_crc, c);
    chk({name, "_rx"}, rx_crc, r);
    chk({name, "_ok"}, 8'(crc_ok), 8'(ok));
  endtask

  task automatic set_zero();
    for (int i = 0; i < NB; i++) pay[i] = 8'h00;
  endtask

  task automatic set_single();
    set_zero();
    pay[NB - 1] = 8'h01;
  endtask

  initial begin
    int         dc;
    bit         q[$];
    logic [7:0] c;
    bit         good;
    logic [15:0] v2;

    reset = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    start2 = 1'b0; bv2 = 1'b0; bi2 = 1'b0;

    // Pin the model with hand-derived remainders.
    q.delete();
    for (int i = 0; i < NBITS - 1; i++) q.push_back(1'b0);
    q.push_back(1'b1);
    for (int i = 0; i < 8; i++) q.push_back(1'b0);
    chk("model_single", mod_p(q), 8'h85);
    q.delete();
    q.push_back(1'b1); q.push_back(1'b0);
    chk("model_x", mod_p(q), 8'h02);

    tick();
    checking = 1'b1;
    tick();
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_done", 8'(done), 8'h00);
    chk("rst_ok", 8'(crc_ok), 8'h00);
    chk("rst_calc", calc_crc, 8'h00);
    chk("rst_rx", rx_crc, 8'h00);
    reset = 1'b0;
    idle(3);

    dc = done_cnt;
    set_single();
    frame(8'h85, 0, BIG);
    expect_done("single", 8'h85, 8'h85, 1'b1);
    idle(2);
    chk("single_done_count", 8'(done_cnt - dc), 8'h01);

    set_zero();
    frame(8'h00, 0, BIG);
    expect_done("zero", 8'h00, 8'h00, 1'b1);
    idle(1);

    set_single();
    frame(8'h84, 0, BIG);
    expect_done("mismatch", 8'h85, 8'h84, 1'b0);
    // Next start lands in the done cycle.
    frame(8'h85, 5, BIG);
    expect_done("gapped", 8'h85, 8'h85, 1'b1);
    idle(2);

    dc = done_cnt;
    set_zero();
    frame(8'h00, 0, 100);
    frame(8'h00, 0, BIG);
    expect_done("restart", 8'h00, 8'h00, 1'b1);
    idle(2);
    chk("restart_done_count", 8'(done_cnt - dc), 8'h01);

    dc = done_cnt;
    set_single();
    frame(8'h85, 2, 200);
    reset = 1'b1;
    bit_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 8'(busy), 8'h00);
    chk("midrst_done", 8'(done), 8'h00);
    chk("midrst_ok", 8'(crc_ok), 8'h00);
    chk("midrst_calc", calc_crc, 8'h00);
    chk("midrst_rx", rx_crc, 8'h00);
    idle(3);
    chk("midrst_no_done", 8'(done_cnt - dc), 8'h00);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NB; i++) pay[i] = 8'($urandom_range(0, 255));
      q.delete();
      for (int i = 0; i < NBITS; i++) begin
        logic [7:0] by;
        by = pay[i / 8];
        q.push_back(by[7 - (i % 8)]);
      end
      for (int i = 0; i < 8; i++) q.push_back(1'b0);
      c    = mod_p(q);
      good = 1'($urandom_range(0, 1));
      if (!good) c = c ^ 8'($urandom_range(1, 255));
      frame(c, int'($urandom_range(0, 3)), BIG);
      chk("rand_done", 8'(done), 8'h01);
      chk("rand_ok", 8'(crc_ok), 8'(good));
      if (k % 3 != 0) idle(int'($urandom_range(0, 4)));
    end
    idle(2);

    // One-byte frame: payload 0x01, CRC 0x85, strobes back to back.
    v2 = 16'h0185;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bv2 = 1'b1;
      bi2 = v2[15 - i];
      if (i == 15) chk("db1_done_early", 8'(done2), 8'h00);
      tick();
    end
    bv2 = 1'b0;
    chk("db1_done", 8'(done2), 8'h01);
    chk("db1_busy", 8'(busy2), 8'h00);
    chk("db1_ok", 8'(ok2), 8'h01);
    chk("db1_calc", calc2, 8'h85);
    chk("db1_rx", rx2, 8'h85);
    tick();
    chk("db1_done_pulse", 8'(done2), 8'h00);
    chk("db1_ok_hold", 8'(ok2), 8'h01);

    idle(2);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
